traductor_ps2_tx: RTL and testbench
===================================

TRADUCTOR_PS2_TX -- requirements
Module: traductor_ps2_tx

Interface
REQ-001 CLK_DIV, 2500, clk cycles per PS/2 clock half-period (50 MHz -> 10 kHz); legal range 2..65535.
REQ-002 GAP_CYCLES, 5000, idle-high clk cycles after every byte's stop bit; legal range 1..65535.
REQ-003 clk  input  1  system clock, rising-edge; the block SHALL use this one clock only.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 cmd  input  4  command: 0 temp24, 1 temp27, 2 temp30, 3 puerta1, 4 puerta0, 5 bebe1, 6 bebe0, 7 terminar, 8 iniciar; 9..15 invalid.
REQ-006 cmd_valid  input  1  cmd is valid this cycle.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 ps2_clk  output  1  PS/2 clock toward the host, idle high.
REQ-009 ps2_data  output  1  PS/2 data toward the host, idle high.
REQ-010 done  output  1  one-cycle pulse when a command's full byte sequence has completed.
REQ-011 cmd_err  output  1  one-cycle pulse when an invalid cmd is accepted.

Function
REQ-012 Scan code map SHALL be: 0->0x16, 1->0x1E, 2->0x26, 3->0x4D, 4->0x21, 5->0x32, 6->0x31, 7->0x5A, 8->0x15.
REQ-013 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1. cmd SHALL be sampled only on that edge.
REQ-014 cmd_ready SHALL be 1 only in IDLE. It SHALL go to 0 on the cycle after acceptance. cmd_valid asserted while cmd_ready=0 SHALL be ignored.
REQ-015 FSM states SHALL be IDLE, START, SHIFT, PARITY, STOP and GAP. The order SHALL be IDLE->START->SHIFT(8 bits)->PARITY->STOP->GAP, then IDLE or START for the next byte.
REQ-016 Frame SHALL be 11 bits: start bit 0, data bits d0..d7 LSB first, odd parity, stop bit 1.
REQ-017 Each bit period SHALL be 2*CLK_DIV cycles. ps2_data SHALL change only at the start of a bit period, while ps2_clk is high. ps2_clk SHALL stay high for CLK_DIV cycles, then low for CLK_DIV cycles.
REQ-018 Latency: ps2_data SHALL be 0 (start bit) on the cycle after acceptance. The first ps2_clk falling edge SHALL occur CLK_DIV cycles after that.
REQ-019 One byte SHALL occupy 22*CLK_DIV cycles followed by GAP_CYCLES cycles with ps2_clk=1 and ps2_data=1.
REQ-020 Parity SHALL be the complement of the XOR of d0..d7.
REQ-021 done SHALL pulse in the last GAP cycle of the final byte. cmd_ready SHALL be 1 on the following cycle.
REQ-022 Invalid cmd handling:
  - it SHALL be accepted, and cmd_err SHALL pulse on the cycle after acceptance;
  - no frame SHALL be sent, and done SHALL NOT pulse;
  - cmd_ready SHALL return to 1 on the cycle after the cmd_err pulse.
REQ-023 The half-period counter SHALL be 16 bits and reload to 0 at each ps2_clk edge. The bit counter SHALL count 0..7 and wrap at the end of SHIFT.
REQ-024 ps2_clk and ps2_data SHALL be registered and glitch-free, driven push-pull.

Reset
REQ-025 While rst_n=0, outputs SHALL be: ps2_clk=1, ps2_data=1, cmd_ready=0, done=0, cmd_err=0, state=IDLE, and all counters 0.
REQ-026 cmd_ready SHALL become 1 on the first rising clk edge after rst_n deasserts.
REQ-027 Reset mid-frame SHALL force both lines high immediately and abandon the frame, with no done pulse. After reset the block SHALL send nothing until a new command is accepted.

Configuration
REQ-028 With macro TRADUCTOR_BREAK_CODE_EN defined, each valid command SHALL send three bytes: code, 0xF0, code. Each byte SHALL be followed by GAP_CYCLES, and done SHALL pulse after the third byte.
REQ-029 Without TRADUCTOR_BREAK_CODE_EN, each valid command SHALL send the make code only, as one byte.

Verification (CLK_DIV=4, GAP_CYCLES=8, macro undefined unless stated)
REQ-030 cmd=0 accepted -> ps2_data bits sampled on ps2_clk falling edges: 0,0,1,1,0,1,0,0,0,0,1 (0x16, parity 0). done pulses 96 cycles after acceptance.
REQ-031 cmd=7 accepted -> bits 0,0,1,0,1,1,0,1,0,1,1 (0x5A, parity 1). cmd_valid held high with cmd=8 during the frame is ignored. 0x15 is sent only after cmd_ready returns to 1.
REQ-032 cmd=12 accepted -> cmd_err pulses once, ps2_clk and ps2_data stay 1, no done pulse, and cmd_ready returns to 1 within 2 cycles.
REQ-033 cmd=3 accepted, rst_n pulled low at cycle 40 -> both lines are 1 in the same cycle, no done pulse, and cmd_ready=1 one edge after release.
REQ-034 TRADUCTOR_BREAK_CODE_EN defined, cmd=3 -> bytes 0x4D, 0xF0, 0x4D, each with parity 1. done pulses at cycle 288.
REQ-035 Back-to-back: cmd=5 accepted, then cmd=6 accepted on the first cycle cmd_ready=1 -> bytes 0x32 and 0x31 separated by exactly 8 idle-high cycles plus 1 accept cycle.

Source files
------------

// File: rtl/traductor_ps2_tx.sv
// traductor_ps2_tx: turns a 4-bit command into a PS/2 device-to-host scan-code
// transmission. Each byte goes out as an 11-bit frame: start, d0..d7, odd
// parity, stop. An idle-high gap follows every byte.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   cmd        command code (0..8 valid, 9..15 invalid)
//   cmd_valid  cmd is valid this cycle
//   cmd_ready  block can accept a command (IDLE only)
//   ps2_clk    PS/2 clock toward the host, idle high
//   ps2_data   PS/2 data toward the host, idle high
//   done       one-cycle pulse in the last gap cycle of the final byte
//   cmd_err    one-cycle pulse after an invalid command is accepted
//
// Parameters:
//   CLK_DIV     clk cycles per PS/2 clock half-period (2..65535)
//   GAP_CYCLES  idle-high clk cycles after each byte's stop bit (1..65535)
//
// Optional feature: define TRADUCTOR_BREAK_CODE_EN to send code, 0xF0, code
// for every valid command instead of the make code alone.
module traductor_ps2_tx #(
  parameter int unsigned CLK_DIV    = 2500,
  parameter int unsigned GAP_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cmd,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       done,
  output logic       cmd_err
);

`ifdef TRADUCTOR_BREAK_CODE_EN
  localparam int unsigned NUM_BYTES = 3;
`else
  localparam int unsigned NUM_BYTES = 1;
`endif

  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [1:0]  LAST_IDX  = 2'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_SHIFT  = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_GAP    = 3'd5
  } state_t;

  // Make-code lookup for the nine legal commands.
  function automatic logic [7:0] scan_code(input logic [3:0] c);
    case (c)
      4'd0:    scan_code = 8'h16;
      4'd1:    scan_code = 8'h1E;
      4'd2:    scan_code = 8'h26;
      4'd3:    scan_code = 8'h4D;
      4'd4:    scan_code = 8'h21;
      4'd5:    scan_code = 8'h32;
      4'd6:    scan_code = 8'h31;
      4'd7:    scan_code = 8'h5A;
      4'd8:    scan_code = 8'h15;
      default: scan_code = 8'h00;
    endcase
  endfunction

  // Byte at position idx of the sequence; position 1 is the break prefix.
  function automatic logic [7:0] seq_byte(input logic [1:0] idx, input logic [7:0] code);
    seq_byte = (idx == 2'd1) ? 8'hF0 : code;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [1:0]  r_idx, w_idx_nxt;
  logic [7:0]  r_code, w_code_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_ps2_clk, w_ps2_clk_nxt;
  logic        r_ps2_data, w_ps2_data_nxt;
  logic        r_cmd_ready, w_cmd_ready_nxt;
  logic        r_done, w_done_nxt;
  logic        r_cmd_err, w_cmd_err_nxt;

  // State and datapath registers; every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_bit       <= 3'd0;
      r_idx       <= 2'd0;
      r_code      <= 8'd0;
      r_shift     <= 8'd0;
      r_ps2_clk   <= 1'b1;
      r_ps2_data  <= 1'b1;
      r_cmd_ready <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_idx       <= w_idx_nxt;
      r_code      <= w_code_nxt;
      r_shift     <= w_shift_nxt;
      r_ps2_clk   <= w_ps2_clk_nxt;
      r_ps2_data  <= w_ps2_data_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_done      <= w_done_nxt;
      r_cmd_err   <= w_cmd_err_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bit_nxt       = r_bit;
    w_idx_nxt       = r_idx;
    w_code_nxt      = r_code;
    w_shift_nxt     = r_shift;
    w_ps2_clk_nxt   = r_ps2_clk;
    w_ps2_data_nxt  = r_ps2_data;
    w_cmd_ready_nxt = 1'b0;
    w_cmd_err_nxt   = 1'b0;
    w_done_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        w_ps2_clk_nxt   = 1'b1;
        w_ps2_data_nxt  = 1'b1;
        if (cmd_valid && r_cmd_ready) begin
          w_cmd_ready_nxt = 1'b0;
          if (cmd <= 4'd8) begin
            // Start bit goes out on the very next cycle.
            w_state_nxt    = S_START;
            w_code_nxt     = scan_code(cmd);
            w_shift_nxt    = scan_code(cmd);
            w_idx_nxt      = 2'd0;
            w_cnt_nxt      = 16'd0;
            w_bit_nxt      = 3'd0;
            w_ps2_data_nxt = 1'b0;
          end else begin
            w_cmd_err_nxt = 1'b1;
          end
        end
      end

      S_START, S_SHIFT, S_PARITY, S_STOP: begin
        if (r_cnt != HALF_LAST) begin
          w_cnt_nxt = r_cnt + 16'd1;
        end else begin
          w_cnt_nxt = 16'd0;
          if (r_ps2_clk) begin
            w_ps2_clk_nxt = 1'b0;
          end else begin
            // End of a bit period: raise clock and present the next bit.
            w_ps2_clk_nxt = 1'b1;
            case (r_state)
              S_START: begin
                w_state_nxt    = S_SHIFT;
                w_bit_nxt      = 3'd0;
                w_ps2_data_nxt = r_shift[0];
              end
              S_SHIFT: begin
                w_bit_nxt = 3'(r_bit + 3'd1);
                if (r_bit == 3'd7) begin
                  w_state_nxt    = S_PARITY;
                  w_ps2_data_nxt = ~(^r_shift);
                end else begin
                  w_ps2_data_nxt = r_shift[w_bit_nxt];
                end
              end
              S_PARITY: begin
                w_state_nxt    = S_STOP;
                w_ps2_data_nxt = 1'b1;
              end
              default: begin
                w_state_nxt    = S_GAP;
                w_ps2_data_nxt = 1'b1;
              end
            endcase
          end
        end
      end

      S_GAP: begin
        w_ps2_clk_nxt  = 1'b1;
        w_ps2_data_nxt = 1'b1;
        if (r_cnt != GAP_LAST) begin
          w_cnt_nxt = r_cnt + 16'd1;
        end else begin
          w_cnt_nxt = 16'd0;
          if (r_idx == LAST_IDX) begin
            w_state_nxt     = S_IDLE;
            w_cmd_ready_nxt = 1'b1;
          end else begin
            w_state_nxt    = S_START;
            w_idx_nxt      = 2'(r_idx + 2'd1);
            w_shift_nxt    = seq_byte(w_idx_nxt, r_code);
            w_bit_nxt      = 3'd0;
            w_ps2_data_nxt = 1'b0;
          end
        end
      end

      default: begin
        w_state_nxt    = S_IDLE;
        w_cnt_nxt      = 16'd0;
        w_ps2_clk_nxt  = 1'b1;
        w_ps2_data_nxt = 1'b1;
      end
    endcase

    // done must be high during the final gap cycle, so decode it one cycle early.
    w_done_nxt = (w_state_nxt == S_GAP) && (w_cnt_nxt == GAP_LAST) && (w_idx_nxt == LAST_IDX);
  end

  assign cmd_ready = r_cmd_ready;
  assign ps2_clk   = r_ps2_clk;
  assign ps2_data  = r_ps2_data;
  assign done      = r_done;
  assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_traductor_ps2_tx.sv
// Scoreboard bench for traductor_ps2_tx: stimulus pushes expected frames,
// start times, done and error times; a negedge monitor decodes the PS/2 lines
// and pops/compares.
module tb_traductor_ps2_tx;

  localparam int unsigned CD       = 4;
  localparam int unsigned GAP      = 8;
  localparam int          BYTE_CYC = 22 * CD + GAP;
`ifdef TRADUCTOR_BREAK_CODE_EN
  localparam int NB = 3;
`else
  localparam int NB = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cmd = 4'd0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready, ps2_clk, ps2_data, done, cmd_err;

  traductor_ps2_tx #(.CLK_DIV(CD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int          q_start[$];
  int          q_done[$];
  int          q_err[$];
  logic [10:0] q_frame[$];

  logic [7:0] code_tab [9] = '{8'h16, 8'h1E, 8'h26, 8'h4D, 8'h21, 8'h32, 8'h31, 8'h5A, 8'h15};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame as seen on successive falling edges: bit0 start, 1..8 data, 9 parity, 10 stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic push_exp(input int c, input int n);
    logic [7:0] b;
    if (c > 8) begin
      q_err.push_back(n + 1);
    end else begin
      for (int k = 0; k < NB; k++) begin
        b = (NB == 3 && k == 1) ? 8'hF0 : code_tab[c];
        q_frame.push_back(ref_frame(b));
        q_start.push_back(n + 1 + k * BYTE_CYC);
      end
      q_done.push_back(n + NB * BYTE_CYC);
    end
  endtask

  // Called at a negedge; returns at a negedge with cmd_ready seen high.
  task automatic wait_ready();
    int t = 0;
    while (!cmd_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", int'(cmd_ready), 1);
  endtask

  task automatic send(input int c, output int n);
    wait_ready();
    cmd = 4'(c);
    cmd_valid = 1'b1;
    n = cyc;
    push_exp(c, n);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  // Monitor
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;
  bit          in_frame = 1'b0;
  int          nfall = 0;
  int          start_c = 0;
  logic [10:0] fr = '0;
  bit          bad_stab = 1'b0;
  bit          bad_tim = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      nfall = 0;
      prev_clk = 1'b1;
      prev_data = 1'b1;
    end else begin
      if (done) begin
        if (q_done.size() == 0) check("done_unexpected", 1, 0);
        else check("done_cycle", cyc, q_done.pop_front());
      end
      if (cmd_err) begin
        if (q_err.size() == 0) check("err_unexpected", 1, 0);
        else check("err_cycle", cyc, q_err.pop_front());
      end
      if (!in_frame) begin
        if (!ps2_data && prev_data) begin
          in_frame = 1'b1;
          nfall = 0;
          start_c = cyc;
          bad_stab = 1'b0;
          bad_tim = 1'b0;
          if (q_start.size() == 0) check("start_unexpected", 1, 0);
          else check("start_cycle", cyc, q_start.pop_front());
        end
      end else begin
        if (!prev_clk && !ps2_clk && (ps2_data != prev_data)) bad_stab = 1'b1;
        if (prev_clk && !ps2_clk) begin
          fr[nfall] = ps2_data;
          if (cyc != start_c + CD + 2 * CD * nfall) bad_tim = 1'b1;
          nfall++;
          if (nfall == 11) begin
            in_frame = 1'b0;
            if (q_frame.size() == 0) check("frame_unexpected", 1, 0);
            else check("frame_bits", int'(fr), int'(q_frame.pop_front()));
            check("data_stable_clk_low", int'(bad_stab), 0);
            check("bit_timing", int'(bad_tim), 0);
          end
        end
      end
      prev_clk = ps2_clk;
      prev_data = ps2_data;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c;
    int t;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ps2_clk", int'(ps2_clk), 1);
    check("rst_ps2_data", int'(ps2_data), 1);
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_cmd_err", int'(cmd_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", int'(cmd_ready), 1);

    // temp24
    send(0, n);

    // terminar, with iniciar held valid while busy
    wait_ready();
    cmd = 4'd7;
    cmd_valid = 1'b1;
    n = cyc;
    push_exp(7, n);
    @(posedge clk);
    #1 cmd = 4'd8;
    @(negedge clk);
    wait_ready();
    n = cyc;
    push_exp(8, n);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);

    // Invalid command
    send(12, n);
    @(negedge clk);
    check("err_ready_back", int'(cmd_ready), 1);
    check("err_line_clk", int'(ps2_clk), 1);
    check("err_line_data", int'(ps2_data), 1);

    // Back-to-back
    send(5, n);
    send(6, n);

    // Reset mid-frame
    send(3, n);
    while (cyc < n + 40) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_ps2_clk", int'(ps2_clk), 1);
    check("midrst_ps2_data", int'(ps2_data), 1);
    check("midrst_ready", int'(cmd_ready), 0);
    q_frame.delete();
    q_start.delete();
    q_done.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", int'(cmd_ready), 1);
    repeat (30) @(negedge clk);

    // Randomised commands
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) c = int'($urandom_range(9, 15));
      else c = int'($urandom_range(0, 8));
      repeat ($urandom_range(0, 12)) @(negedge clk);
      send(c, n);
    end

    // Drain
    t = 0;
    while ((q_done.size() + q_frame.size() + q_err.size() + q_start.size()) != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (40) @(negedge clk);
    check("drain_done_q", q_done.size(), 0);
    check("drain_frame_q", q_frame.size(), 0);
    check("drain_start_q", q_start.size(), 0);
    check("drain_err_q", q_err.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
